// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the UART transmit path.
//
// Contents:
//   ST_IDLE / ST_ISSUE / ST_WAIT  FSM state encodings of uart_tx_arbiter.
//                                 They are 2-bit constants so that older
//                                 blocks can compare against raw state values.
//   TIMEOUT_CYCLES_DEFAULT        Default tx_done watchdog length, in cycles.
//   idx_width()                   Width of a requester index, never below 1.
// ============================================================================
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam int TIMEOUT_CYCLES_DEFAULT = 200000;

    // $clog2(2) is 1 but $clog2(1) is 0. Clamping keeps every index
    // register at least one bit wide for any legal requester count.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// ============================================================================
// rr_select
// ----------------------------------------------------------------------------
// Combinational round-robin picker. It searches upward (modulo NREQ) starting
// one above last_grant. It returns the first requester whose req bit is set.
// The last winner therefore gets the lowest priority on the next pick.
//
// Parameters:
//   NREQ   number of requesters (2..8)
//   IDX_W  width of a requester index
//
// Ports:
//   req         in   NREQ   active request lines
//   last_grant  in   IDX_W  index of the previous winner
//   winner      out  IDX_W  index of the selected requester (0 when !valid)
//   valid       out  1      at least one request is pending
// ============================================================================
module rr_select
    import uart_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable assigned in this block gets a value before the
        // loop. Without that, a path that never assigns it would infer a latch.
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        // Offsets run from 1 to NREQ. The last candidate tried is last_grant
        // itself, so a lone requester can win twice in a row.
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDX_W'((int'(last_grant) + off) % NREQ);
            if (!valid && req[cand]) begin
                winner = cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter
// ----------------------------------------------------------------------------
// Shares one UART transceiver TX path among NREQ requesters.
//
// A three-state FSM does the work:
//   IDLE  -> picks a winner by round-robin, latches its byte into tx_data.
//   ISSUE -> one cycle: tx_wr and gnt[owner] are both high.
//   WAIT  -> waits for tx_done from the transceiver. On tx_done it pulses
//            done[owner] and returns to IDLE.
// tx_done is ignored in every state except WAIT.
//
// Optional feature (macro UART_TX_ARB_TIMEOUT_EN):
//   A watchdog counts cycles spent in WAIT. After TIMEOUT_CYCLES cycles
//   without tx_done, the FSM leaves WAIT, pulses done[owner], and sets the
//   sticky timeout_err flag. When the macro is undefined, the counter and the
//   timeout_err port are absent.
//
// Parameters:
//   NREQ            number of requesters (2..8)
//   TIMEOUT_CYCLES  watchdog length in cycles (only with the macro)
//
// Ports:
//   sys_clk      in   1       clock, rising edge
//   sys_rst      in   1       synchronous, active-high reset
//   req          in   NREQ    level requests, held until gnt
//   req_data     in   8*NREQ  byte of requester i on [8i+7:8i]
//   gnt          out  NREQ    one-hot pulse: byte of that requester accepted
//   done         out  NREQ    one-hot pulse: byte of that requester sent
//   tx_data      out  8       byte to the transceiver, held between issues
//   tx_wr        out  1       write strobe to the transceiver
//   tx_done      in   1       end-of-stop-bit pulse from the transceiver
//   busy         out  1       FSM is not in IDLE
//   timeout_err  out  1       sticky watchdog flag (only with the macro)
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_done,
    output logic              busy
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam int IDX_W = idx_width(NREQ);

    logic [1:0]       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] winner;
    logic             win_valid;
    logic [NREQ-1:0]  owner_onehot;
    logic             wait_exit;     // WAIT ends at the coming edge

    // ------------------------------------------------------------------
    // Round-robin winner selection
    // ------------------------------------------------------------------
    rr_select #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner),
        .valid      (win_valid)
    );

    always_comb begin
        owner_onehot        = '0;
        owner_onehot[owner] = 1'b1;
    end

    // ------------------------------------------------------------------
    // WAIT exit condition: tx_done, or the watchdog when it is built
    // ------------------------------------------------------------------
`ifdef UART_TX_ARB_TIMEOUT_EN
    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int TO_W = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    // The counter is 0 in the first WAIT cycle. It reaches TIMEOUT_CYCLES-1
    // in the last cycle allowed. A tx_done in that same cycle wins, so a
    // transfer that just makes it is not flagged.
    assign to_hit    = (state == ST_WAIT) && !tx_done &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign wait_exit = tx_done || to_hit;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((state == ST_WAIT) && !wait_exit) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
            if (to_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign wait_exit = tx_done;
`endif

    // ------------------------------------------------------------------
    // Main FSM
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        // NOTE: state registers use non-blocking assignments. All of them then
        // update together at the edge, so the order of statements does not
        // matter.
        if (sys_rst) begin
            state      <= ST_IDLE;
            owner      <= '0;
            // Reset points last_grant at the top requester, so the first
            // search starts at requester 0.
            last_grant <= IDX_W'(NREQ - 1);
            tx_data    <= 8'h00;
            done       <= '0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        // {winner, 3'b000} is exactly the width needed to
                        // index req_data, so the byte select stays exact.
                        tx_data    <= req_data[{winner, 3'b000} +: 8];
                        owner      <= winner;
                        last_grant <= winner;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A tx_done that coincides with tx_wr belongs to an
                    // earlier byte or is spurious. It is dropped here.
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_exit) begin
                        done  <= owner_onehot;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    assign tx_wr = (state == ST_ISSUE);
    assign gnt   = tx_wr ? owner_onehot : '0;
    assign busy  = (state != ST_IDLE);

endmodule
